button_step_generator: RTL and testbench
========================================

# button_step_generator

Upstream stage for the synchronous counter. It turns a raw, bouncing, asynchronous push-button into a clean single-cycle `step` pulse that drives the counter's `enable` input, so each press advances the count by exactly one. While the button is held, it generates further steps (auto-repeat). It also exports the debounced button level.

## Interface
Parameters:
- `DB_CYCLES`, default 4: consecutive stable cycles required to accept a press or a release. Must be ≥ 2.
- `HOLD_CYCLES`, default 10: cycles in the held state before auto-repeat starts. Must be ≥ 2.
- `REPEAT_CYCLES`, default 3: auto-repeat period in cycles. Must be ≥ 2.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  input  1  rising-edge clock.
- `reset_n`  input  1  asynchronous active-low reset.
- `btn_in`  input  1  raw button, asynchronous to `clk`, may bounce.
- `repeat_en`  input  1  synchronous level; enables auto-repeat.
- `step`  output  1  registered one-cycle pulse; connects to the counter's `enable`.
- `btn_level`  output  1  registered debounced button level.

## Operation
- **Synchronizer:** `btn_in` passes through two flops (`s1` → `btn_s`). The FSM uses only `btn_s`.
- **Timer:** a single shared timer, width `$clog2` of the largest parameter. It is cleared on every state transition and increments by 1 each cycle the FSM stays in a timed state. It never wraps, because every terminal value forces a transition or a clear.
- **FSM states:** IDLE, DB_PRESS, HELD, REPEAT, DB_REL.
  - **IDLE:** `btn_s`=1 → DB_PRESS.
  - **DB_PRESS:**
    - `btn_s`=0 → IDLE. No step.
    - `btn_s`=1 and timer==DB_CYCLES-1 → HELD. Assert `step`.
  - **HELD:**
    - `btn_s`=0 → DB_REL.
    - `btn_s`=1, `repeat_en`=1 and timer==HOLD_CYCLES-1 → REPEAT. Assert `step`.
    - With `repeat_en`=0 the timer saturates at HOLD_CYCLES-1 and the FSM stays in HELD.
  - **REPEAT:**
    - `btn_s`=0 → DB_REL.
    - `repeat_en`=0 → HELD. No step.
    - timer==REPEAT_CYCLES-1 → assert `step` and clear the timer; stay in REPEAT.
  - **DB_REL:**
    - `btn_s`=1 → HELD with the timer cleared. No step; the hold delay restarts.
    - timer==DB_CYCLES-1 with `btn_s`=0 → IDLE.
- **Outputs:**
  - `step` is high for exactly the one cycle after an edge marked "assert `step`" above. It is never high on two consecutive cycles.
  - `btn_level` is 1 in HELD, REPEAT and DB_REL, and 0 in IDLE and DB_PRESS. It is registered alongside the state.
- **Priority:** a release (`btn_s`=0) beats repeat/hold expiry in the same cycle; no step is issued.
- **Reset (asserted, asynchronous):**
  - `s1`, `btn_s`, `step`, `btn_level` and the timer go to 0; the state goes to IDLE.
  - Mid-operation reset behaves the same. After deassertion, a still-held button is re-synchronized and fully re-debounced.

## Timing
- **Press latency:** with `btn_in` stable high from edge e, FSM samples `btn_s`=1 at edge e+2 and `step` rises after edge e+DB_CYCLES+2. Default: e+6.
- **First repeat:** HOLD_CYCLES edges after the first step. Each following repeat comes every REPEAT_CYCLES edges.
- **Release latency:** with `btn_in` stable low from edge r, `btn_level` falls after edge r+DB_CYCLES+2.
- **Glitch rejection:**
  - A press bounce shorter than DB_CYCLES cycles at `btn_s` produces no step.
  - A release glitch shorter than DB_CYCLES keeps `btn_level`=1.
- **Throughput:** at most one step per REPEAT_CYCLES cycles. Steps never overlap the counter's carry timing, because `step` is a clean single-cycle registered signal.

## Test plan
Defaults for all scenarios: DB_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3.
1. **Clean press:** `btn_in` high from edge 0 for 12 cycles, `repeat_en`=1, then low → one step after edge 6; `btn_level` 1 from edge 6; `btn_level` 0 after edge 12+6=18; no further step.
2. **Bounce:** `btn_in` 1,1,0,1,1,1,0 then low → `step` never asserts; `btn_level` stays 0.
3. **Long hold:** `btn_in` high from edge 0 for 30 cycles, `repeat_en`=1 → steps after edges 6, 16, 19, 22, 25, 28, 31. Driving `step` into a 4-bit counter gives Q=7.
4. **Release glitch in HELD:** `btn_in` low for 2 cycles at edge 9, then high → `btn_level` stays 1, no step, hold timer restarts. The next step comes 10 edges after DB_REL→HELD.
5. **Reset mid-repeat:** `reset_n` low at edge 20 while held → `step`=0 and `btn_level`=0 immediately. After release with the button still high, the first step follows the sixth edge after deassertion.
6. **Repeat disabled:** `repeat_en`=0, `btn_in` high for 40 cycles → exactly one step. Raising `repeat_en` at cycle 40 → next step at HOLD_CYCLES expiry (immediate next edge, since the timer is saturated), then every 3 cycles.

Source files
------------

// File: rtl/button_step_generator.sv
// button_step_generator
//   Turns a raw, bouncing push-button into a clean one-cycle step pulse with
//   debounce on press and release, plus optional auto-repeat while held.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   btn_in     raw button, asynchronous to clk, may bounce
//   repeat_en  synchronous level, enables auto-repeat while held
//   step       registered one-cycle pulse (feeds a counter enable)
//   btn_level  registered debounced button level
module button_step_generator #(
  parameter int unsigned DB_CYCLES     = 4,
  parameter int unsigned HOLD_CYCLES   = 10,
  parameter int unsigned REPEAT_CYCLES = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_in,
  input  logic repeat_en,
  output logic step,
  output logic btn_level
);

  localparam int unsigned MAX_DH  = (DB_CYCLES > HOLD_CYCLES) ? DB_CYCLES : HOLD_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_DH > REPEAT_CYCLES) ? MAX_DH : REPEAT_CYCLES;
  localparam int unsigned TW      = $clog2(MAX_CYC);

  localparam logic [TW-1:0] DB_LAST   = TW'(DB_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] DB_PRESS = 3'd1;
  localparam logic [2:0] HELD     = 3'd2;
  localparam logic [2:0] REPEAT   = 3'd3;
  localparam logic [2:0] DB_REL   = 3'd4;

  logic          s1;
  logic          btn_s;
  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          step_d;
  logic          btn_level_d;

  // Two-flop synchronizer; only btn_s is seen by the FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1    <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      s1    <= btn_in;
      btn_s <= s1;
    end
  end

  // Every branch either clears the timer on a transition or increments it
  // below its terminal value, so it never wraps.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    step_d  = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (btn_s) state_d = DB_PRESS;
      end
      DB_PRESS: begin
        if (!btn_s) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == DB_LAST) begin
          state_d = HELD;
          timer_d = '0;
          step_d  = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_d = DB_REL;
          timer_d = '0;
        end else if (timer_q == HOLD_LAST) begin
          // Saturate here until repeat is enabled.
          if (repeat_en) begin
            state_d = REPEAT;
            timer_d = '0;
            step_d  = 1'b1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      REPEAT: begin
        if (!btn_s) begin
          state_d = DB_REL;
          timer_d = '0;
        end else if (!repeat_en) begin
          state_d = HELD;
          timer_d = '0;
        end else if (timer_q == REP_LAST) begin
          timer_d = '0;
          step_d  = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DB_REL: begin
        if (btn_s) begin
          // Release was a glitch: back to held, hold delay restarts.
          state_d = HELD;
          timer_d = '0;
        end else if (timer_q == DB_LAST) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_comb begin
    btn_level_d = (state_d == HELD) || (state_d == REPEAT) || (state_d == DB_REL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      step      <= 1'b0;
      btn_level <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      step      <= step_d;
      btn_level <= btn_level_d;
    end
  end

endmodule

// File: tb/tb_button_step_generator.sv
// Self-checking bench for button_step_generator (default parameters).
// Stimulus pushes the edge index at which each step is expected; a monitor
// pops and compares whenever step is seen high.
module tb_button_step_generator;

  logic clk = 1'b0;
  logic reset_n;
  logic btn_in;
  logic repeat_en;
  logic step;
  logic btn_level;

  int errors = 0;
  int checks = 0;
  int edge_cnt = -1;
  int total_steps = 0;
  int exp_q[$];
  logic prev_step = 1'b0;

  always #5 clk = ~clk;

  button_step_generator #(
    .DB_CYCLES     (4),
    .HOLD_CYCLES   (10),
    .REPEAT_CYCLES (3)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_in    (btn_in),
    .repeat_en (repeat_en),
    .step      (step),
    .btn_level (btn_level)
  );

  // Index of the most recent rising edge.
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor: compare each observed step against the scoreboard.
  always @(negedge clk) begin
    int e;
    if (reset_n) begin
      if (step) begin
        total_steps++;
        checks++;
        if (prev_step) begin
          errors++;
          $display("FAIL step_single: step high on consecutive cycles at edge %0d", edge_cnt);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL step_time: step after edge %0d, required no step", edge_cnt);
        end else begin
          e = exp_q.pop_front();
          if (e != edge_cnt) begin
            errors++;
            $display("FAIL step_time: step after edge %0d, required after edge %0d", edge_cnt, e);
          end
        end
      end
      prev_step = step;
    end else begin
      prev_step = 1'b0;
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Expected steps still pending are steps that never came.
  task automatic drain(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected step(s) missing, next at edge %0d",
               name, exp_q.size(), exp_q[0]);
      exp_q.delete();
    end
  endtask

  // Called at a negedge: btn_in is sampled by the next n rising edges.
  task automatic drive(input logic v, input int n);
    btn_in = v;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int b;
    int s0;
    logic [3:0] q;
    logic pat [7];
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    reset_n   = 1'b0;
    btn_in    = 1'b0;
    repeat_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_step", step, 1'b0);
    chk("reset_level", btn_level, 1'b0);
    reset_n = 1'b1;
    drive(1'b0, 4);

    // 1: clean press, 12 cycles high.
    b = edge_cnt + 1;
    exp_q.push_back(b + 6);
    drive(1'b1, 6);
    chk("s1_level_before", btn_level, 1'b0);
    drive(1'b1, 1);
    chk("s1_level_on", btn_level, 1'b1);
    drive(1'b1, 5);
    drive(1'b0, 6);
    chk("s1_level_held", btn_level, 1'b1);
    drive(1'b0, 1);
    chk("s1_level_off", btn_level, 1'b0);
    drive(1'b0, 8);
    drain("s1_steps");

    // 2: bounce shorter than the debounce window.
    foreach (pat[i]) begin
      drive(pat[i], 1);
      chk("s2_level", btn_level, 1'b0);
    end
    drive(1'b0, 6);
    chk("s2_level_end", btn_level, 1'b0);
    drive(1'b0, 6);
    drain("s2_steps");

    // 3: long hold with auto-repeat; step feeds a 4-bit counter.
    b  = edge_cnt + 1;
    s0 = total_steps;
    exp_q.push_back(b + 6);
    exp_q.push_back(b + 16);
    exp_q.push_back(b + 19);
    exp_q.push_back(b + 22);
    exp_q.push_back(b + 25);
    exp_q.push_back(b + 28);
    exp_q.push_back(b + 31);
    drive(1'b1, 30);
    drive(1'b0, 6);
    chk("s3_level_held", btn_level, 1'b1);
    drive(1'b0, 1);
    chk("s3_level_off", btn_level, 1'b0);
    drive(1'b0, 6);
    drain("s3_steps");
    q = 4'(total_steps - s0);
    chk_int("s3_counter", int'(q), 7);

    // 4: two-cycle release glitch while held.
    b = edge_cnt + 1;
    exp_q.push_back(b + 6);
    exp_q.push_back(b + 23);
    drive(1'b1, 9);
    drive(1'b0, 2);
    drive(1'b1, 2);
    chk("s4_level_dbrel", btn_level, 1'b1);
    drive(1'b1, 1);
    chk("s4_level_reheld", btn_level, 1'b1);
    drive(1'b1, 9);
    drive(1'b0, 6);
    chk("s4_level_held", btn_level, 1'b1);
    drive(1'b0, 1);
    chk("s4_level_off", btn_level, 1'b0);
    drive(1'b0, 6);
    drain("s4_steps");

    // 5: reset while repeating (step is high right after edge 19).
    b = edge_cnt + 1;
    exp_q.push_back(b + 6);
    exp_q.push_back(b + 16);
    exp_q.push_back(b + 19);
    drive(1'b1, 20);
    chk("s5_step_pre", step, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("s5_reset_step", step, 1'b0);
    chk("s5_reset_level", btn_level, 1'b0);
    drain("s5_steps_pre");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    // First edge after deassertion is edge 0 of the re-press.
    b = edge_cnt + 1;
    exp_q.push_back(b + 6);
    drive(1'b1, 10);
    drive(1'b0, 6);
    chk("s5_level_held", btn_level, 1'b1);
    drive(1'b0, 1);
    chk("s5_level_off", btn_level, 1'b0);
    drive(1'b0, 6);
    drain("s5_steps_post");

    // 6: repeat disabled, then enabled with the hold timer saturated.
    repeat_en = 1'b0;
    b = edge_cnt + 1;
    exp_q.push_back(b + 6);
    drive(1'b1, 40);
    drain("s6_single_step");
    repeat_en = 1'b1;
    exp_q.push_back(b + 40);
    exp_q.push_back(b + 43);
    exp_q.push_back(b + 46);
    drive(1'b1, 5);
    drive(1'b0, 6);
    chk("s6_level_held", btn_level, 1'b1);
    drive(1'b0, 1);
    chk("s6_level_off", btn_level, 1'b0);
    drive(1'b0, 6);
    drain("s6_repeat_steps");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
